// File: rtl/ifmap_byte_fifo.sv
// Byte-granular ifmap FIFO: accepts byte or 32-bit word pushes and returns one byte per pop.
// Latency: a popped byte appears on pop_data_o/pop_valid_o one cycle after the accepted pop_en_i.
// Backpressure: a push without room, or a pop from an empty FIFO, is dropped and raises a sticky flag.
module ifmap_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_reset_i,
  input  logic                     push_en_i,
  input  logic [31:0]              push_data_i,
  input  logic                     push_mod_i,
  input  logic                     pop_en_i,
  output logic [7:0]               pop_data_o,
  output logic                     pop_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     word_space_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] WORD_LIMIT  = CW'(DEPTH - 4);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic          push_byte_ok;
  logic          push_word_ok;
  logic          push_ok;
  logic          push_rej;
  logic          pop_ok;
  logic          pop_rej;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] pop_amt;

  // Space decisions use only the count held at the start of the cycle, so a
  // same-cycle pop never makes room for a push and vice versa.
  assign push_byte_ok = push_en_i & ~push_mod_i & (count != DEPTH_C);
  assign push_word_ok = push_en_i &  push_mod_i & (count <= WORD_LIMIT);
  assign push_ok      = push_byte_ok | push_word_ok;
  assign push_rej     = push_en_i & ~push_ok;
  assign pop_ok       = pop_en_i & (count != '0);
  assign pop_rej      = pop_en_i & (count == '0);
  assign push_amt     = push_word_ok ? CW'(4) : (push_byte_ok ? CW'(1) : '0);
  assign pop_amt      = pop_ok ? CW'(1) : '0;

  // Status outputs are decodes of the registered count only.
  assign full_o       = (count == DEPTH_C);
  assign empty_o      = (count == '0);
  assign word_space_o = (count <= WORD_LIMIT);
  assign count_o      = count;

  // Storage write; byte lanes land at consecutive addresses, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst && !fifo_reset_i && push_ok) begin
      if (push_word_ok) begin
        for (int k = 0; k < 4; k++) begin
          mem[wptr + AW'(k)] <= push_data_i[8*k +: 8];
        end
      end else begin
        mem[wptr] <= push_data_i[7:0];
      end
    end
  end

  // Pointer, count, read-data and sticky flag state; rst outranks the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      pop_data_o  <= '0;
      pop_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (fifo_reset_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      pop_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + (push_word_ok ? AW'(4) : AW'(1));
      end
      if (pop_ok) begin
        rptr       <= rptr + AW'(1);
        pop_data_o <= mem[rptr];
      end
      pop_valid_o <= pop_ok;
      count       <= count + push_amt - pop_amt;
      if (push_rej) begin
        overflow_o <= 1'b1;
      end
      if (pop_rej) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifmap_byte_fifo.sv
// Directed self-checking bench for ifmap_byte_fifo at DEPTH=16.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Every expected value below is hand-computed from the block's behaviour.
module tb_ifmap_byte_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_reset_i;
  logic        push_en_i;
  logic [31:0] push_data_i;
  logic        push_mod_i;
  logic        pop_en_i;
  logic [7:0]  pop_data_o;
  logic        pop_valid_o;
  logic        full_o;
  logic        empty_o;
  logic        word_space_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifmap_byte_fifo #(.DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_reset_i (fifo_reset_i),
    .push_en_i    (push_en_i),
    .push_data_i  (push_data_i),
    .push_mod_i   (push_mod_i),
    .pop_en_i     (pop_en_i),
    .pop_data_o   (pop_data_o),
    .pop_valid_o  (pop_valid_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .word_space_o (word_space_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_reset_i = 1'b0;
    push_en_i    = 1'b0;
    push_mod_i   = 1'b0;
    push_data_i  = '0;
    pop_en_i     = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_en_i = 1'b1; push_mod_i = 1'b0; push_data_i = {24'h0, b};
    tick();
    idle();
  endtask

  task automatic push_word(input logic [31:0] w);
    push_en_i = 1'b1; push_mod_i = 1'b1; push_data_i = w;
    tick();
    idle();
  endtask

  task automatic pop_one();
    pop_en_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic flush();
    fifo_reset_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full_o); end
    total++; if (word_space_o !== 1'b1) begin bad++; $display("FAIL reset_word_space got=%b exp=1", word_space_o); end
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid_o); end
    total++; if (pop_data_o !== 8'h00) begin bad++; $display("FAIL reset_pop_data got=%h exp=00", pop_data_o); end
    total++; if ({overflow_o, underflow_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow_o, underflow_o}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      total++; if (count_o !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, i + 1); end
    end
    total++; if (full_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full_o); end
    total++; if (word_space_o !== 1'b0) begin bad++; $display("FAIL fill_word_space got=%b exp=0", word_space_o); end
    push_byte(8'hAA);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b exp=1", overflow_o); end
    total++; if (count_o !== 5'd16) begin bad++; $display("FAIL fill_rejected_count got=%0d exp=16", count_o); end
    for (int i = 0; i < 16; i++) begin
      pop_one();
      total++; if (pop_valid_o !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, pop_valid_o); end
      total++; if (pop_data_o !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, pop_data_o, 8'(i)); end
    end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty_o); end
    tick();
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", pop_valid_o); end
    total++; if (pop_data_o !== 8'h0F) begin bad++; $display("FAIL idle_hold_data got=%h exp=0f", pop_data_o); end
    total++; if (underflow_o !== 1'b0) begin bad++; $display("FAIL drain_underflow got=%b exp=0", underflow_o); end
  endtask

  task automatic test_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    flush();
    push_word(32'h4433_2211);
    total++; if (count_o !== 5'd4) begin bad++; $display("FAIL word_count got=%0d exp=4", count_o); end
    for (int i = 0; i < 4; i++) begin
      pop_one();
      total++; if (pop_data_o !== exp_b[i]) begin bad++; $display("FAIL word_byte[%0d] got=%h exp=%h", i, pop_data_o, exp_b[i]); end
      total++; if (count_o !== 5'(3 - i)) begin bad++; $display("FAIL word_pop_count[%0d] got=%0d exp=%0d", i, count_o, 3 - i); end
    end
  endtask

  task automatic test_word_space();
    flush();
    for (int i = 0; i < 13; i++) push_byte(8'(8'h20 + i));
    total++; if (word_space_o !== 1'b0) begin bad++; $display("FAIL ws13_word_space got=%b exp=0", word_space_o); end
    push_word(32'hDDCC_BBAA);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ws13_overflow got=%b exp=1", overflow_o); end
    total++; if (count_o !== 5'd13) begin bad++; $display("FAIL ws13_count got=%0d exp=13", count_o); end
    pop_one();
    total++; if (pop_data_o !== 8'h20) begin bad++; $display("FAIL ws12_pop got=%h exp=20", pop_data_o); end
    total++; if (word_space_o !== 1'b1) begin bad++; $display("FAIL ws12_word_space got=%b exp=1", word_space_o); end
    push_word(32'hDDCC_BBAA);
    total++; if (count_o !== 5'd16) begin bad++; $display("FAIL ws16_count got=%0d exp=16", count_o); end
    total++; if (full_o !== 1'b1) begin bad++; $display("FAIL ws16_full got=%b exp=1", full_o); end
    for (int i = 0; i < 12; i++) pop_one();
    total++; if (pop_data_o !== 8'h2C) begin bad++; $display("FAIL ws_last_byte got=%h exp=2c", pop_data_o); end
    pop_one();
    total++; if (pop_data_o !== 8'hAA) begin bad++; $display("FAIL ws_word_lane0 got=%h exp=aa", pop_data_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4];
    exp_b = '{8'h21, 8'h43, 8'h65, 8'h87};
    flush();
    for (int i = 0; i < 14; i++) push_byte(8'hE0);
    for (int i = 0; i < 14; i++) pop_one();
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL wrap_setup_count got=%0d exp=0", count_o); end
    // Both pointers sit at 14 with the FIFO empty, so the same-cycle pop is refused.
    push_en_i = 1'b1; push_mod_i = 1'b1; push_data_i = 32'h8765_4321; pop_en_i = 1'b1;
    tick();
    idle();
    total++; if (count_o !== 5'd4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", count_o); end
    total++; if (underflow_o !== 1'b1) begin bad++; $display("FAIL wrap_underflow got=%b exp=1", underflow_o); end
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL wrap_pop_valid got=%b exp=0", pop_valid_o); end
    for (int i = 0; i < 4; i++) begin
      pop_one();
      total++; if (pop_data_o !== exp_b[i]) begin bad++; $display("FAIL wrap_byte[%0d] got=%h exp=%h", i, pop_data_o, exp_b[i]); end
    end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_empty_push_pop();
    flush();
    push_en_i = 1'b1; push_mod_i = 1'b0; push_data_i = 32'h0000_0077; pop_en_i = 1'b1;
    tick();
    idle();
    total++; if (underflow_o !== 1'b1) begin bad++; $display("FAIL epp_underflow got=%b exp=1", underflow_o); end
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL epp_pop_valid got=%b exp=0", pop_valid_o); end
    total++; if (count_o !== 5'd1) begin bad++; $display("FAIL epp_count got=%0d exp=1", count_o); end
    // Flush with a push and pop in the same cycle: both must be ignored.
    fifo_reset_i = 1'b1; push_en_i = 1'b1; pop_en_i = 1'b1;
    tick();
    idle();
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    total++; if ({overflow_o, underflow_o, pop_valid_o} !== 3'b000) begin bad++; $display("FAIL flush_flags got=%b exp=000", {overflow_o, underflow_o, pop_valid_o}); end
  endtask

  task automatic test_reset_midstream();
    flush();
    for (int i = 0; i < 7; i++) push_byte(8'(8'h90 + i));
    total++; if (count_o !== 5'd7) begin bad++; $display("FAIL mid_setup_count got=%0d exp=7", count_o); end
    rst = 1'b1; pop_en_i = 1'b1; push_en_i = 1'b1; push_data_i = 32'h0000_00FF;
    tick();
    rst = 1'b0;
    idle();
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b exp=1", empty_o); end
    total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL mid_pop_valid got=%b exp=0", pop_valid_o); end
    push_byte(8'h5A);
    pop_one();
    total++; if (pop_data_o !== 8'h5A) begin bad++; $display("FAIL mid_after_pop got=%h exp=5a", pop_data_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL mid_final_empty got=%b exp=1", empty_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill_drain();
    test_word();
    test_word_space();
    test_wrap();
    test_empty_push_pop();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
